// File: rtl/key_debounce.sv
// key_debounce: per-channel two-flop synchronizer plus stability-window debouncer for active-low pushbuttons.
// Latency: key_clean/key_press/key_release change DEBOUNCE_CYCLES+1 clocks after s1 first samples a clean step.
// Backpressure: none; free-running, every output is valid on every cycle.
//
// Ports:
//   clk           - single system clock, all logic on the rising edge
//   reset_n       - asynchronous active-low reset (forces released state)
//   key_raw       - asynchronous pushbutton inputs, active-low (0 = pressed)
//   key_clean     - debounced level, active-low
//   key_press     - one-clock active-high pulse when key_clean goes 1->0
//   key_release   - one-clock active-high pulse when key_clean goes 0->1
//   press_cnt_clr - (optional) synchronous clear of the press counters
//   press_count   - (optional) 8-bit wrapping press count per channel, channel i in [8i+7:8i]
//
// Optional feature: define KEY_DEBOUNCE_PRESS_CNT_EN to add press_cnt_clr / press_count
// and the per-channel press counters. Without it the ports and logic are absent.

module key_debounce #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] key_raw,
   output logic [WIDTH-1:0] key_clean,
   output logic [WIDTH-1:0] key_press,
   output logic [WIDTH-1:0] key_release
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
   ,
   input  logic               press_cnt_clr,
   output logic [8*WIDTH-1:0] press_count
`endif
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2(DEBOUNCE_CYCLES)) bits suffice.
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] differ;   // synchronized input disagrees with the debounced level
   logic [WIDTH-1:0] expire;   // disagreement has lasted the full window this edge

   // Two-flop synchronizer; resets to released so a held key is seen as a fresh press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '1;
         s2 <= '1;
      end else begin
         s1 <= key_raw;
         s2 <= s1;
      end
   end

   assign differ = s2 ^ key_clean;

   // One private counter per channel. Any agreement between s2 and key_clean
   // restarts the window, which is what rejects glitches and bounce trains.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CW-1:0] cnt;

      assign expire[i] = differ[i] && (cnt == CNT_MAX);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt <= '0;
         end else if (!differ[i] || expire[i]) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Debounced level and edge pulses update on the same edge. The direction of
   // the change is given by the old key_clean value: 1 means a press is landing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_clean   <= '1;
         key_press   <= '0;
         key_release <= '0;
      end else begin
         key_clean   <= key_clean ^ expire;
         key_press   <= expire & key_clean;
         key_release <= expire & ~key_clean;
      end
   end

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
   // Counts pulses already visible on key_press. A clear coinciding with a
   // press loads 1 so that press is not lost.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pcnt
      logic [7:0] pcnt;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pcnt <= '0;
         end else if (press_cnt_clr) begin
            pcnt <= key_press[i] ? 8'd1 : 8'd0;
         end else if (key_press[i]) begin
            pcnt <= pcnt + 8'd1;   // wraps 255 -> 0
         end
      end

      assign press_count[8*i +: 8] = pcnt;
   end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: self-checking bench for key_debounce (WIDTH=4, DEBOUNCE_CYCLES=8).
// Reference: sliding window over the raw samples; a channel flips when the D samples
// that reached s2 (raw delayed two edges) all disagree with the debounced level.
// Optional: KEY_DEBOUNCE_PRESS_CNT_EN also exercises press_count / press_cnt_clr.

module tb_key_debounce;

   localparam int W = 4;
   localparam int D = 8;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] key_raw;
   logic [W-1:0] key_clean;
   logic [W-1:0] key_press;
   logic [W-1:0] key_release;
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
   logic           press_cnt_clr;
   logic [8*W-1:0] press_count;
`endif

   key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_raw     (key_raw),
      .key_clean   (key_clean),
      .key_press   (key_press),
      .key_release (key_release)
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
      ,
      .press_cnt_clr (press_cnt_clr),
      .press_count   (press_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   logic [W-1:0] hist [0:D+1];   // hist[j] = raw sampled j edges ago
   logic [W-1:0] m_clean;
   logic [W-1:0] m_press;
   logic [W-1:0] m_rel;

   task automatic model_reset();
      for (int j = 0; j <= D + 1; j++) hist[j] = '1;
      m_clean = '1;
      m_press = '0;
      m_rel   = '0;
   endtask

   task automatic model_edge(input logic rst_now, input logic [W-1:0] raw);
      logic all_lo;
      logic all_hi;
      if (!rst_now) begin
         model_reset();
      end else begin
         for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = raw;
         m_press = '0;
         m_rel   = '0;
         for (int ch = 0; ch < W; ch++) begin
            all_lo = 1'b1;
            all_hi = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
               if (hist[j][ch]) all_lo = 1'b0;
               else             all_hi = 1'b0;
            end
            if (m_clean[ch] && all_lo) begin
               m_clean[ch] = 1'b0;
               m_press[ch] = 1'b1;
            end else if (!m_clean[ch] && all_hi) begin
               m_clean[ch] = 1'b1;
               m_rel[ch]   = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // One clock: model sees the same sample as the DUT, outputs compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge(reset_n, key_raw);
      #1;
      check("clean",   32'(key_clean),   32'(m_clean));
      check("press",   32'(key_press),   32'(m_press));
      check("release", 32'(key_release), 32'(m_rel));
   endtask

   task automatic hold(input logic [W-1:0] raw, input int n);
      key_raw = raw;
      for (int k = 0; k < n; k++) tick();
   endtask

   // Ticks up to 'limit' edges and returns the index of the first press on 'ch' (-1 if none).
   task automatic find_press(input int ch, input int limit, output int idx, output int npress);
      idx    = -1;
      npress = 0;
      for (int n = 0; n < limit; n++) begin
         tick();
         if (key_press[ch]) begin
            npress++;
            if (idx < 0) idx = n;
         end
      end
   endtask

   typedef struct {
      logic [W-1:0] raw;
      int           hold;
      logic [W-1:0] exp_clean;
      logic [W-1:0] exp_press;   // channels that pulse exactly once in this row
      logic [W-1:0] exp_rel;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int idx;
      int np;
      int pc [W];
      int rc [W];
      logic [W-1:0] once_p, once_r, many;

      tbl[0] = '{4'b1110, 20, 4'b1110, 4'b0001, 4'b0000};  // clean press on key 0
      tbl[1] = '{4'b1111, 20, 4'b1111, 4'b0000, 4'b0001};  // release key 0
      tbl[2] = '{4'b1101,  7, 4'b1111, 4'b0000, 4'b0000};  // 7-cycle glitch on key 1
      tbl[3] = '{4'b1111, 12, 4'b1111, 4'b0000, 4'b0000};  // glitch rejected
      tbl[4] = '{4'b1101,  8, 4'b1111, 4'b0000, 4'b0000};  // 8-cycle low on key 1
      tbl[5] = '{4'b1111, 12, 4'b1111, 4'b0010, 4'b0010};  // reported, then released
      tbl[6] = '{4'b0110, 20, 4'b0110, 4'b1001, 4'b0000};  // keys 0 and 3 together
      tbl[7] = '{4'b1111, 20, 4'b1111, 4'b0000, 4'b1001};

      model_reset();
      key_raw = 4'b0000;
      reset_n = 1'b1;
`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
      press_cnt_clr = 1'b0;
`endif
      #2 reset_n = 1'b0;

      // Reset with all keys held: released state, no pulses.
      for (int k = 0; k < 3; k++) tick();
      check("rst_clean", 32'(key_clean), 32'hF);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_rel",   32'(key_release), 32'h0);

      // Release reset with keys held: all four report 9 edges after the first s1 sample.
      reset_n = 1'b1;
      find_press(0, 20, idx, np);
      check("rst_held_press_edge", 32'(idx), 32'd9);
      check("rst_held_press_num",  32'(np),  32'd1);
      check("rst_held_clean",      32'(key_clean), 32'h0);
      hold(4'b1111, 20);

      // Table-driven vectors.
      for (int r = 0; r < 8; r++) begin
         for (int ch = 0; ch < W; ch++) begin
            pc[ch] = 0;
            rc[ch] = 0;
         end
         key_raw = tbl[r].raw;
         for (int k = 0; k < tbl[r].hold; k++) begin
            tick();
            for (int ch = 0; ch < W; ch++) begin
               pc[ch] += int'(key_press[ch]);
               rc[ch] += int'(key_release[ch]);
            end
         end
         for (int ch = 0; ch < W; ch++) begin
            once_p[ch] = (pc[ch] == 1);
            once_r[ch] = (rc[ch] == 1);
            many[ch]   = (pc[ch] > 1) || (rc[ch] > 1);
         end
         check($sformatf("row%0d_clean", r), 32'(key_clean), 32'(tbl[r].exp_clean));
         check($sformatf("row%0d_press", r), 32'(once_p), 32'(tbl[r].exp_press));
         check($sformatf("row%0d_rel", r),   32'(once_r), 32'(tbl[r].exp_rel));
         check($sformatf("row%0d_multi", r), 32'(many), 32'h0);
      end

      // Bounce train on key 2: toggles every 3 cycles for 30 cycles, then stable low.
      np = 0;
      for (int seg = 0; seg < 10; seg++) begin
         key_raw = (seg % 2 == 0) ? 4'b1011 : 4'b1111;
         for (int k = 0; k < 3; k++) begin
            tick();
            np += int'(key_press[2]);
         end
      end
      check("bounce_no_early", 32'(np), 32'd0);
      key_raw = 4'b1011;
      find_press(2, 20, idx, np);
      check("bounce_press_edge", 32'(idx), 32'd9);
      check("bounce_press_num",  32'(np),  32'd1);
      hold(4'b1111, 20);

      // Reset mid-count: key 0 counter reaches 5, then reset discards it.
      hold(4'b1110, 7);
      reset_n = 1'b0;
      #1;
      check("async_rst_clean", 32'(key_clean), 32'hF);
      for (int k = 0; k < 3; k++) tick();
      check("midrst_clean", 32'(key_clean), 32'hF);
      check("midrst_press", 32'(key_press), 32'h0);
      reset_n = 1'b1;
      find_press(0, 20, idx, np);
      check("midrst_full_window", 32'(idx), 32'd9);
      check("midrst_press_num",   32'(np),  32'd1);
      hold(4'b1111, 20);

      // Randomized segments, with occasional reset pulses.
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 19) == 0) begin
            reset_n = 1'b0;
            tick();
            tick();
            reset_n = 1'b1;
         end
         hold(W'($urandom), int'($urandom_range(1, 14)));
      end
      hold(4'b1111, 20);
      check("rand_final_clean", 32'(key_clean), 32'hF);

`ifdef KEY_DEBOUNCE_PRESS_CNT_EN
      press_cnt_clr = 1'b1;
      tick();
      press_cnt_clr = 1'b0;
      check("pcnt_cleared", 32'(press_count), 32'h0);
      for (int p = 0; p < 257; p++) begin
         hold(4'b1110, 12);
         hold(4'b1111, 12);
      end
      check("pcnt_wrap", 32'(press_count), 32'h0000_0001);
      hold(4'b1110, 12);
      hold(4'b1111, 12);
      check("pcnt_two", 32'(press_count[7:0]), 32'd2);
      // Clear raised during the cycle the press pulse is visible.
      key_raw = 4'b1110;
      idx = -1;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (press_cnt_clr) press_cnt_clr = 1'b0;
         if (key_press[0] && idx < 0) begin
            idx = n;
            press_cnt_clr = 1'b1;
         end
      end
      check("pcnt_clr_press_seen", 32'(idx), 32'd9);
      check("pcnt_clr_collide", 32'(press_count[7:0]), 32'd1);
      hold(4'b1111, 12);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of pushbutton channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): stability window in clocks; legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port key_raw, input, WIDTH bits: asynchronous board pushbuttons, active-low (0 = pressed).
REQ-006 SHALL have port key_clean, output, WIDTH bits: debounced level, active-low; drop-in for the CPU key input PIO.
REQ-007 SHALL have port key_press, output, WIDTH bits: one-clock active-high pulse per debounced press.
REQ-008 SHALL have port key_release, output, WIDTH bits: one-clock active-high pulse per debounced release.

Function
REQ-009 SHALL pass each key_raw bit through a private two-flop synchronizer (s1, then s2) before any other use.
REQ-010 SHALL keep, per channel, an independent counter of ceil(log2(DEBOUNCE_CYCLES)) bits, with no sharing between channels.
REQ-011 SHALL clear the counter on any edge where s2 equals key_clean.
REQ-012 SHALL increment the counter on any edge where s2 differs from key_clean and counter < DEBOUNCE_CYCLES-1.
REQ-013 SHALL, on the edge where s2 differs from key_clean and counter = DEBOUNCE_CYCLES-1, load key_clean <= s2 and clear the counter.
REQ-014 SHALL give a fixed latency: for a clean input step, key_clean changes on the (DEBOUNCE_CYCLES+1)th rising edge after the edge at which s1 first samples the new value.
REQ-015 SHALL treat any return of s2 to the key_clean value before expiry as a glitch: counter cleared, no output change, no pulse.
REQ-016 SHALL register key_press on the same edge key_clean goes 1->0, held high exactly one cycle.
REQ-017 SHALL register key_release on the same edge key_clean goes 0->1, held high exactly one cycle.
REQ-018 SHALL drive key_press and key_release low in every other cycle, and never assert both for one channel in the same cycle.
REQ-019 SHALL process channels fully independently; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 SHALL hold a key held indefinitely at a constant key_clean with no repeated pulses.

Reset
REQ-021 SHALL, while reset_n = 0, force s1, s2 and key_clean to all-ones (released), all counters to 0, and key_press/key_release to 0, immediately and without a clock.
REQ-022 SHALL, on reset asserted mid-count, discard the pending transition; after release, a held key SHALL need a full new window before reporting.
REQ-023 SHALL, on reset_n deassertion with a key already held, report that key with a normal key_press pulse after REQ-014 latency.

Configuration
REQ-024 SHALL gate press counting with macro KEY_DEBOUNCE_PRESS_CNT_EN.
REQ-025 SHALL, when KEY_DEBOUNCE_PRESS_CNT_EN is defined, add port press_cnt_clr (input, 1 bit, synchronous clear) and port press_count (output, 8*WIDTH bits; channel i in bits [8i+7:8i]).
REQ-026 SHALL, under that macro, increment channel i's 8-bit count on each key_press[i], wrap 255->0, and reset it to 0.
REQ-027 SHALL, when press_cnt_clr and key_press[i] occur in the same cycle, set count i to 1 so no press is lost.
REQ-028 SHALL, when KEY_DEBOUNCE_PRESS_CNT_EN is undefined, have neither port nor counter logic present; all other behaviour is identical.

Verification (bench uses DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-029 SHALL cover reset: hold reset_n=0 with key_raw=4'b0000 -> key_clean=4'b1111, pulses 0; release -> key_press=4'b1111 for one cycle, exactly 9 edges after the first s1 sample.
REQ-030 SHALL cover a clean press: key_raw[0] 1->0 held 20 cycles -> key_clean[0]=0 on edge 9, one key_press[0] pulse, key_clean[3:1] unchanged.
REQ-031 SHALL cover glitch rejection: key_raw[1] low for 7 cycles then high -> no key_clean change, no pulse; low for 8 cycles -> press reported.
REQ-032 SHALL cover a bounce train: key_raw[2] toggling every 3 cycles for 30 cycles, then stable low -> exactly one key_press[2], 9 edges after the last edge.
REQ-033 SHALL cover simultaneous events and reset mid-count: press keys 0 and 3 on the same edge -> both pulses in the same cycle; assert reset at count 5 -> counters 0, no pulse.
REQ-034 SHALL cover the macro build: 257 presses on key 0 -> press_count[7:0]=1; press_cnt_clr on the same cycle as a press -> count 1.
